// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter between NUM_REQ byte streams.
// Supports packet locking, a flow-control hold and forced release of a stalled lock owner.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 flow_hold,
  input  logic                 tx_idle,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_flag
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t        state;
  logic          lock;
  logic [2:0]    rr_ptr;
  logic [CW-1:0] stall_cnt;

  logic          owner_valid;
  logic          rr_found;
  logic [2:0]    rr_sel;
  logic          cand_found;
  logic [2:0]    sel;
  logic [7:0]    sel_data;
  logic          sel_last;
  logic          accept;
  logic          stall;
  logic          release_lock;

  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 3'(i)) owner_valid = req_valid[i];
    end
  end

  // Walk from the farthest position back to rr_ptr+1 so the nearest valid requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(rr_ptr) + k) % NUM_REQ && req_valid[i]) begin
          rr_found = 1'b1;
          rr_sel   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    if (lock) begin
      cand_found = owner_valid;
      sel        = owner;
    end else begin
      cand_found = rr_found;
      sel        = rr_sel;
    end
  end

  always_comb begin
    sel_data = 8'd0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == 3'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  assign accept = !reset && (state == S_IDLE) && tx_idle && !flow_hold && cand_found;

  // A stall only counts while the transmitter could actually take the owner's next byte.
  assign stall        = (state == S_IDLE) && lock && !owner_valid && tx_idle && !flow_hold;
  assign release_lock = stall && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept && sel == 3'(i)) req_ready[i] = 1'b1;
    end
  end

  assign busy = (state != S_IDLE) || lock;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      lock         <= 1'b0;
      rr_ptr       <= 3'(NUM_REQ - 1);
      owner        <= 3'd0;
      tx_start     <= 1'b0;
      tx_data      <= 8'd0;
      timeout_flag <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            tx_data  <= sel_data;
            owner    <= sel;
            rr_ptr   <= sel;
            lock     <= ~sel_last;
            tx_start <= 1'b1;
            state    <= S_START;
          end else if (release_lock) begin
            lock         <= 1'b0;
            timeout_flag <= 1'b1;
          end
        end
        S_START: state <= S_GUARD;
        // The transmitter's idle flag lags the start pulse, so it is not trusted here.
        S_GUARD: state <= S_WAIT;
        S_WAIT: begin
          if (tx_idle) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (stall && !release_lock) stall_cnt <= stall_cnt + 1'b1;
      else                        stall_cnt <= '0;
    end
  end

endmodule
